// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the memory-mapped system timer.
//   - register word offsets (s_addr[3:2])
//   - CTRL / STATUS bit positions and the PRE field LSB
//   - byte-lane to bit-mask expansion helper
package timer_pkg;

    typedef enum logic [1:0] {
        TMR_CTRL   = 2'd0,
        TMR_COUNT  = 2'd1,
        TMR_CMP    = 2'd2,
        TMR_STATUS = 2'd3
    } tmr_reg_e;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_AUTO_BIT   = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;
    localparam int CTRL_PRE_LSB    = 16;

    localparam int ST_MATCH_BIT = 0;
    localparam int ST_OVF_BIT   = 1;

    // Expand 4 byte-lane enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock by (pre + 1) while enabled.
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   en    in   enable; counter held at 0 while low
//   pre   in   divider value; tick fires when the counter equals it
//   tick  out  one-cycle pulse, combinational from counter state
module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] pre,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] r_cnt;

    // The comparison uses the live pre value, so a PRE rewrite applies to the
    // next comparison without disturbing the running count.
    assign tick = en && (r_cnt == pre);

    // en is the registered EN bit: on the edge that writes EN=0 the counter
    // still advances once, but tick is blocked for the whole disabled period
    // and the counter is zero again before any re-enable can take effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!en || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/timer_slave.sv
// timer_slave: 32-bit system timer on a BIU slave port.
// Registers (word offset s_addr[3:2]):
//   0 CTRL   : bit0 EN, bit1 AUTO, bit2 IRQ_EN, [16 +: PRESCALE_W] PRE
//   1 COUNT  : up-counter, read/write
//   2 CMP    : compare value, read/write
//   3 STATUS : bit0 MATCH, bit1 OVF, write-1-to-clear via byte lane 0
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   s_we        write strobe
//   s_addr      byte address (only [3:2] decoded)
//   s_addr_sel  byte-lane write enables
//   s_wdata     write data
//   s_rdata     combinational read data
//   irq         level interrupt = IRQ_EN & (MATCH | OVF)
module timer_slave
    import timer_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_we,
    input  logic [31:0] s_addr,
    input  logic [3:0]  s_addr_sel,
    input  logic [31:0] s_wdata,
    output logic [31:0] s_rdata,
    output logic        irq
);

    logic                  r_en;
    logic                  r_auto;
    logic                  r_irq_en;
    logic [PRESCALE_W-1:0] r_pre;
    logic [31:0]           r_count;
    logic [31:0]           r_cmp;
    logic                  r_match;
    logic                  r_ovf;

    logic                  w_tick;
    tmr_reg_e              w_reg;
    logic [31:0]           w_mask;
    logic                  w_wr_ctrl;
    logic                  w_wr_count;
    logic                  w_wr_cmp;
    logic                  w_wr_status;
    logic [31:0]           w_count_tick;
    logic [31:0]           w_count_next;
    logic                  w_set_match;
    logic                  w_set_ovf;
    logic                  w_clr_match;
    logic                  w_clr_ovf;
    logic [PRESCALE_W-1:0] w_pre_next;
    logic [31:0]           w_rdata;
    logic                  w_unused_addr;

    // Only the word offset is decoded.
    assign w_unused_addr = ^{s_addr[31:4], s_addr[1:0]};

    assign w_reg       = tmr_reg_e'(s_addr[3:2]);
    assign w_mask      = lane_mask(s_addr_sel);
    assign w_wr_ctrl   = s_we && (w_reg == TMR_CTRL);
    assign w_wr_count  = s_we && (w_reg == TMR_COUNT);
    assign w_wr_cmp    = s_we && (w_reg == TMR_CMP);
    assign w_wr_status = s_we && (w_reg == TMR_STATUS);

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (r_en),
        .pre   (r_pre),
        .tick  (w_tick)
    );

    // Tick update first, then the software write overlays only its enabled
    // lanes, so unwritten lanes keep the tick-updated value.
    always_comb begin
        w_count_tick = r_count;
        w_set_match  = 1'b0;
        w_set_ovf    = 1'b0;
        if (w_tick) begin
            if (r_count == r_cmp) begin
                w_set_match  = 1'b1;
                w_count_tick = r_auto ? 32'd0 : r_count + 32'd1;
            end else if (r_count == 32'hFFFF_FFFF) begin
                w_set_ovf    = 1'b1;
                w_count_tick = 32'd0;
            end else begin
                w_count_tick = r_count + 32'd1;
            end
        end
        if (w_wr_count) begin
            w_count_next = (w_count_tick & ~w_mask) | (s_wdata & w_mask);
        end else begin
            w_count_next = w_count_tick;
        end
    end

    assign w_pre_next = (r_pre & ~w_mask[CTRL_PRE_LSB +: PRESCALE_W])
                      | (s_wdata[CTRL_PRE_LSB +: PRESCALE_W] & w_mask[CTRL_PRE_LSB +: PRESCALE_W]);

    assign w_clr_match = w_wr_status && s_addr_sel[0] && s_wdata[ST_MATCH_BIT];
    assign w_clr_ovf   = w_wr_status && s_addr_sel[0] && s_wdata[ST_OVF_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en     <= 1'b0;
            r_auto   <= 1'b0;
            r_irq_en <= 1'b0;
            r_pre    <= '0;
            r_count  <= '0;
            r_cmp    <= '0;
            r_match  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                if (s_addr_sel[0]) begin
                    r_en     <= s_wdata[CTRL_EN_BIT];
                    r_auto   <= s_wdata[CTRL_AUTO_BIT];
                    r_irq_en <= s_wdata[CTRL_IRQ_EN_BIT];
                end
                r_pre <= w_pre_next;
            end
            if (w_wr_cmp) begin
                r_cmp <= (r_cmp & ~w_mask) | (s_wdata & w_mask);
            end
            r_count <= w_count_next;
            // Hardware set wins over a simultaneous write-1-to-clear.
            r_match <= w_set_match | (r_match & ~w_clr_match);
            r_ovf   <= w_set_ovf   | (r_ovf   & ~w_clr_ovf);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            TMR_CTRL: begin
                w_rdata[CTRL_EN_BIT]                 = r_en;
                w_rdata[CTRL_AUTO_BIT]               = r_auto;
                w_rdata[CTRL_IRQ_EN_BIT]             = r_irq_en;
                w_rdata[CTRL_PRE_LSB +: PRESCALE_W]  = r_pre;
            end
            TMR_COUNT: w_rdata = r_count;
            TMR_CMP:   w_rdata = r_cmp;
            TMR_STATUS: begin
                w_rdata[ST_MATCH_BIT] = r_match;
                w_rdata[ST_OVF_BIT]   = r_ovf;
            end
            default: w_rdata = '0;
        endcase
    end

    assign s_rdata = w_rdata;
    assign irq     = r_irq_en & (r_match | r_ovf);

endmodule

// File: tb/tb_timer_slave.sv
module tb_timer_slave;

    logic        clk;
    logic        rst_n;
    logic        s_we;
    logic [31:0] s_addr;
    logic [3:0]  s_addr_sel;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state, kept at register-map level.
    logic [31:0] m_ctrl;   // CTRL as read back
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    logic        m_match;
    logic        m_ovf;
    int unsigned m_phase;  // cycles into the current prescale period

    timer_slave #(.PRESCALE_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_we       (s_we),
        .s_addr     (s_addr),
        .s_addr_sel (s_addr_sel),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_ctrl;
            2'd1:    return m_count;
            2'd2:    return m_cmp;
            default: return {30'd0, m_ovf, m_match};
        endcase
    endfunction

    function automatic logic m_irq();
        return m_ctrl[2] & (m_match | m_ovf);
    endfunction

    task automatic m_reset();
        m_ctrl = '0; m_count = '0; m_cmp = '0;
        m_match = 1'b0; m_ovf = 1'b0; m_phase = 0;
    endtask

    // Advance the reference by one clock edge with the given bus write.
    task automatic m_step(input logic we, input logic [1:0] a, input logic [3:0] sel,
                          input logic [31:0] wd);
        logic        en;
        int unsigned pre;
        logic        tick;
        logic [31:0] cnt;
        logic        set_m, set_o, clr_m, clr_o;
        logic [31:0] mask;
        en    = m_ctrl[0];
        pre   = int'(m_ctrl[31:16]);
        tick  = en && (m_phase == pre);
        cnt   = m_count;
        set_m = 1'b0;
        set_o = 1'b0;
        if (tick) begin
            if (m_count == m_cmp) begin
                set_m = 1'b1;
                cnt = m_ctrl[1] ? 32'd0 : m_count + 32'd1;
            end else if (m_count == 32'hFFFF_FFFF) begin
                set_o = 1'b1;
                cnt = 32'd0;
            end else begin
                cnt = m_count + 32'd1;
            end
        end
        m_phase = (!en || tick) ? 0 : (m_phase + 1) % 65536;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        clr_m = 1'b0;
        clr_o = 1'b0;
        if (we) begin
            case (a)
                2'd0: m_ctrl = ((m_ctrl & ~mask) | (wd & mask)) & 32'hFFFF_0007;
                2'd1: cnt = (cnt & ~mask) | (wd & mask);
                2'd2: m_cmp = (m_cmp & ~mask) | (wd & mask);
                default: begin
                    clr_m = sel[0] & wd[0];
                    clr_o = sel[0] & wd[1];
                end
            endcase
        end
        m_count = cnt;
        m_match = set_m | (m_match & ~clr_m);
        m_ovf   = set_o | (m_ovf & ~clr_o);
    endtask

    // One bus cycle: drive in the low phase, check the pre-edge read and irq,
    // take the edge, update the reference, return in the next low phase.
    task automatic cyc(input logic we, input logic [1:0] a, input logic [3:0] sel,
                       input logic [31:0] wd);
        s_we = we; s_addr = {28'h0, a, 2'b00}; s_addr_sel = sel; s_wdata = wd;
        #1;
        chk("rdata", s_rdata, m_read(a));
        chk("irq", {31'd0, irq}, {31'd0, m_irq()});
        @(posedge clk);
        m_step(we, a, sel, wd);
        @(negedge clk);
        s_we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] sel, input logic [31:0] wd);
        cyc(1'b1, a, sel, wd);
    endtask

    task automatic idle();
        cyc(1'b0, 2'd1, 4'h0, 32'h0);
    endtask

    // Combinational read within the current low phase, against a fixed value.
    task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
        s_we = 1'b0; s_addr = {28'h0, a, 2'b00};
        #1;
        chk(tag, s_rdata, exp);
    endtask

    initial begin
        s_we = 1'b0; s_addr = '0; s_addr_sel = '0; s_wdata = '0;
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while running with COUNT=0x10, EN=1.
        wr(2'd1, 4'hF, 32'h10);
        wr(2'd0, 4'hF, 32'hFFFF_0005);
        peek("pre_rst_count", 2'd1, 32'h10);
        rst_n = 1'b0;
        m_reset();
        peek("rst_ctrl", 2'd0, 32'h0);
        peek("rst_count", 2'd1, 32'h0);
        peek("rst_cmp", 2'd2, 32'h0);
        peek("rst_status", 2'd3, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        peek("rel_ctrl", 2'd0, 32'h0);
        peek("rel_count", 2'd1, 32'h0);
        peek("rel_cmp", 2'd2, 32'h0);
        @(negedge clk);
        peek("rel_status", 2'd3, 32'h0);
        chk("rel_irq", {31'd0, irq}, 32'd0);

        // Byte lanes.
        wr(2'd2, 4'b0101, 32'hAABB_CCDD);
        peek("lane_cmp", 2'd2, 32'h00BB_00DD);

        // Periodic match, CMP=3, PRE=0.
        wr(2'd2, 4'hF, 32'd3);
        wr(2'd0, 4'hF, 32'h0000_0007);
        peek("per_c0", 2'd1, 32'd0);
        idle(); peek("per_c1", 2'd1, 32'd1);
        idle(); peek("per_c2", 2'd1, 32'd2);
        chk("per_irq_lo", {31'd0, irq}, 32'd0);
        idle(); peek("per_c3", 2'd1, 32'd3);
        idle(); peek("per_wrap", 2'd1, 32'd0);
        peek("per_match", 2'd3, 32'd1);
        chk("per_irq_hi", {31'd0, irq}, 32'd1);
        wr(2'd3, 4'h1, 32'd1);
        peek("w1c_status", 2'd3, 32'd0);
        chk("w1c_irq", {31'd0, irq}, 32'd0);
        // COUNT is now 1; reach 3 then W1C on the matching tick.
        idle(); idle();
        peek("col_c3", 2'd1, 32'd3);
        wr(2'd3, 4'h1, 32'd1);
        peek("col_match_kept", 2'd3, 32'd1);
        // COUNT write during a tick cycle.
        wr(2'd1, 4'hF, 32'h100);
        peek("col_count_wr", 2'd1, 32'h100);
        idle();
        peek("col_count_inc", 2'd1, 32'h101);

        // Overflow.
        wr(2'd0, 4'hF, 32'h0);
        wr(2'd3, 4'h1, 32'h3);
        wr(2'd1, 4'hF, 32'hFFFF_FFFE);
        wr(2'd2, 4'hF, 32'd5);
        wr(2'd0, 4'hF, 32'h0000_0005);
        peek("ovf_c0", 2'd1, 32'hFFFF_FFFE);
        idle(); peek("ovf_c1", 2'd1, 32'hFFFF_FFFF);
        idle(); peek("ovf_c2", 2'd1, 32'h0);
        peek("ovf_status", 2'd3, 32'h2);
        chk("ovf_irq", {31'd0, irq}, 32'd1);

        // Prescaler PRE=3, with disable/re-enable.
        wr(2'd0, 4'hF, 32'h0);
        wr(2'd3, 4'h1, 32'h3);
        wr(2'd1, 4'hF, 32'h0);
        wr(2'd2, 4'hF, 32'hFFFF);
        wr(2'd0, 4'hF, 32'h0003_0001);
        for (int i = 0; i < 3; i++) begin
            idle(); peek("pre_hold0", 2'd1, 32'd0);
        end
        idle(); peek("pre_inc1", 2'd1, 32'd1);
        idle(); idle();
        wr(2'd0, 4'hF, 32'h0003_0000);
        wr(2'd0, 4'hF, 32'h0003_0001);
        for (int i = 0; i < 3; i++) begin
            idle(); peek("pre_hold1", 2'd1, 32'd1);
        end
        idle(); peek("pre_inc2", 2'd1, 32'd2);

        // Randomised traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            int unsigned op;
            logic [1:0]  a;
            logic [3:0]  sel;
            logic [31:0] d;
            op  = $urandom_range(0, 9);
            a   = 2'($urandom_range(0, 3));
            sel = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            case (a)
                2'd0: d = {16'($urandom_range(0, 3)), 13'($urandom), 3'($urandom_range(0, 7))};
                2'd1: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4))
                                                       : 32'($urandom_range(0, 8));
                2'd2: d = 32'($urandom_range(0, 8));
                default: d = $urandom;
            endcase
            if (op < 4) begin
                cyc(1'b0, a, 4'h0, 32'h0);
            end else begin
                cyc(1'b1, a, sel, d);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
